egg_timer_counter: RTL and testbench

Countdown core of the egg timer. Holds a user-set MM:SS time as four BCD digits and counts it down at 1 Hz derived from the system clock. Raises an alarm at 00:00. Each digit output drives one BCD-to-7-segment decoder directly; digits are always in the range 0-9.

---
 rtl/egg_timer_pkg.sv | 45 ++++
 rtl/mmss_bcd_counter.sv | 96 +++++++++
 rtl/egg_timer_counter.sv | 188 ++++++++++++++++++
 tb/tb_egg_timer_counter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/egg_timer_pkg.sv
// Shared types, constants and BCD digit helpers for the egg timer countdown core.
//   state_t : controller states (IDLE, RUN, PAUSE, ALARM)
//   bcd_t   : one BCD digit, 0-9
//   bcd_inc : next value of a digit that counts up to 'max', with wrap flag in bit 4
//   bcd_dec : next value of a digit that counts down from 'max', with borrow flag in bit 4
package egg_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    // Count up; any value at or above 'max' wraps to 0 so a corrupted digit
    // returns to the legal range on its next increment.
    function automatic logic [4:0] bcd_inc(input bcd_t d, input bcd_t max);
        logic [4:0] res;
        if (d >= max) begin
            res = {1'b1, 4'd0};
        end else begin
            res = {1'b0, d + 4'd1};
        end
        return res;
    endfunction

    // Count down; 0 reloads 'max' and raises the borrow flag.
    function automatic logic [4:0] bcd_dec(input bcd_t d, input bcd_t max);
        logic [4:0] res;
        if (d == 4'd0) begin
            res = {1'b1, max};
        end else if (d > max) begin
            res = {1'b0, max};
        end else begin
            res = {1'b0, d - 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/mmss_bcd_counter.sv
// Registered four-digit MM:SS store used by the egg timer.
//   clk, reset          : clock and synchronous active-high reset
//   load_zero           : force 00:00 (highest priority)
//   dec                 : decrement by one second with BCD borrow (ignored at 00:00)
//   inc_min, inc_sec    : add one minute / one second, each wrapping within its own field
//   min_tens..sec_ones  : registered BCD digits
//   is_zero             : the stored time is 00:00
module mmss_bcd_counter
    import egg_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_zero,
    input  logic       inc_min,
    input  logic       inc_sec,
    input  logic       dec,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       is_zero
);

    bcd_t min_tens_r, min_ones_r, sec_tens_r, sec_ones_r;
    bcd_t min_tens_nx_s, min_ones_nx_s, sec_tens_nx_s, sec_ones_nx_s;

    logic [4:0] so_inc_s, st_inc_s, mo_inc_s, mt_inc_s;
    logic [4:0] so_dec_s, st_dec_s, mo_dec_s, mt_dec_s;
    logic       zero_s;
    logic       b_st_s, b_mo_s, b_mt_s;

    assign so_inc_s = bcd_inc(sec_ones_r, DIGIT_MAX);
    assign st_inc_s = bcd_inc(sec_tens_r, SEC_TENS_MAX);
    assign mo_inc_s = bcd_inc(min_ones_r, DIGIT_MAX);
    assign mt_inc_s = bcd_inc(min_tens_r, DIGIT_MAX);

    assign so_dec_s = bcd_dec(sec_ones_r, DIGIT_MAX);
    assign st_dec_s = bcd_dec(sec_tens_r, SEC_TENS_MAX);
    assign mo_dec_s = bcd_dec(min_ones_r, DIGIT_MAX);
    assign mt_dec_s = bcd_dec(min_tens_r, DIGIT_MAX);

    // Borrow ripples upward only while every lower digit is wrapping.
    assign b_st_s = so_dec_s[4];
    assign b_mo_s = b_st_s & st_dec_s[4];
    assign b_mt_s = b_mo_s & mo_dec_s[4];

    assign zero_s = (min_tens_r == 4'd0) && (min_ones_r == 4'd0) &&
                    (sec_tens_r == 4'd0) && (sec_ones_r == 4'd0);

    // Next-time selection: zero load, then decrement, then the two field increments.
    always_comb begin
        min_tens_nx_s = min_tens_r;
        min_ones_nx_s = min_ones_r;
        sec_tens_nx_s = sec_tens_r;
        sec_ones_nx_s = sec_ones_r;
        if (load_zero) begin
            min_tens_nx_s = 4'd0;
            min_ones_nx_s = 4'd0;
            sec_tens_nx_s = 4'd0;
            sec_ones_nx_s = 4'd0;
        end else if (dec && !zero_s) begin
            sec_ones_nx_s = so_dec_s[3:0];
            sec_tens_nx_s = b_st_s ? st_dec_s[3:0] : sec_tens_r;
            min_ones_nx_s = b_mo_s ? mo_dec_s[3:0] : min_ones_r;
            min_tens_nx_s = b_mt_s ? mt_dec_s[3:0] : min_tens_r;
        end else begin
            // Seconds wrap 59->00 without touching the minutes field.
            sec_ones_nx_s = inc_sec ? so_inc_s[3:0] : sec_ones_r;
            sec_tens_nx_s = (inc_sec && so_inc_s[4]) ? st_inc_s[3:0] : sec_tens_r;
            min_ones_nx_s = inc_min ? mo_inc_s[3:0] : min_ones_r;
            min_tens_nx_s = (inc_min && mo_inc_s[4]) ? mt_inc_s[3:0] : min_tens_r;
        end
    end

    // Digit registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            min_tens_r <= 4'd0;
            min_ones_r <= 4'd0;
            sec_tens_r <= 4'd0;
            sec_ones_r <= 4'd0;
        end else begin
            min_tens_r <= min_tens_nx_s;
            min_ones_r <= min_ones_nx_s;
            sec_tens_r <= sec_tens_nx_s;
            sec_ones_r <= sec_ones_nx_s;
        end
    end

    assign min_tens = min_tens_r;
    assign min_ones = min_ones_r;
    assign sec_tens = sec_tens_r;
    assign sec_ones = sec_ones_r;
    assign is_zero  = zero_s;

endmodule

// File: rtl/egg_timer_counter.sv
// Egg timer countdown core: MM:SS time store, 1 Hz prescaler, run/pause/alarm control.
//   clk, reset      : clock and synchronous active-high reset
//   start_stop      : pulse - start (non-zero time), pause, resume, acknowledge alarm
//   clear           : pulse - abort and zero the time from any state
//   inc_min/inc_sec : pulses - edit the time while idle
//   min_tens..sec_ones : registered BCD digits for the display decoders
//   running / alarm : registered state flags
// Same-cycle priority: clear > start_stop > inc_*.
module egg_timer_counter
    import egg_timer_pkg::*;
#(
    parameter int TICK_DIV   = 32'd50000000,
    parameter int ALARM_SECS = 32'd10
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       inc_min,
    input  logic       inc_sec,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       alarm
);

    localparam int              PW         = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
    localparam logic [PW-1:0]   TICK_LAST  = PW'(TICK_DIV - 32'd1);
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(32'd1);
    localparam logic [3:0]      ALARM_LAST = 4'(ALARM_SECS - 32'd1);

    state_t        state_r;
    logic [PW-1:0] presc_r;
    logic [3:0]    alarm_cnt_r;
    logic          running_r;
    logic          alarm_r;

    logic tick_s;
    logic last_sec_s;
    logic is_zero_s;
    logic load_zero_s;
    logic dec_s;
    logic inc_min_s;
    logic inc_sec_s;

    logic [3:0] min_tens_s, min_ones_s, sec_tens_s, sec_ones_s;

    assign tick_s = (presc_r == TICK_LAST);

    // The decrement that lands on 00:00 is the one taken from 00:01.
    assign last_sec_s = (min_tens_s == 4'd0) && (min_ones_s == 4'd0) &&
                        (sec_tens_s == 4'd0) && (sec_ones_s == 4'd1);

    // Digit-store command decode with input priority applied.
    always_comb begin
        load_zero_s = 1'b0;
        dec_s       = 1'b0;
        inc_min_s   = 1'b0;
        inc_sec_s   = 1'b0;
        if (clear) begin
            load_zero_s = 1'b1;
        end else if (start_stop) begin
            // A pause request swallows any tick of the same cycle.
            load_zero_s = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    dec_s = tick_s;
                end
                IDLE: begin
                    inc_min_s = inc_min;
                    inc_sec_s = inc_sec;
                end
                default: begin
                    dec_s = 1'b0;
                end
            endcase
        end
    end

    mmss_bcd_counter u_mmss (
        .clk       (clk),
        .reset     (reset),
        .load_zero (load_zero_s),
        .inc_min   (inc_min_s),
        .inc_sec   (inc_sec_s),
        .dec       (dec_s),
        .min_tens  (min_tens_s),
        .min_ones  (min_ones_s),
        .sec_tens  (sec_tens_s),
        .sec_ones  (sec_ones_s),
        .is_zero   (is_zero_s)
    );

    // Controller: state, prescaler, alarm second counter and registered flags.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_r     <= IDLE;
            presc_r     <= {PW{1'b0}};
            alarm_cnt_r <= 4'd0;
            running_r   <= 1'b0;
            alarm_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Held at zero so the first running second is a full one.
                    presc_r     <= {PW{1'b0}};
                    alarm_cnt_r <= 4'd0;
                    alarm_r     <= 1'b0;
                    if (start_stop && !is_zero_s) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end else begin
                        running_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        state_r   <= PAUSE;
                        running_r <= 1'b0;
                        // Fraction is frozen; a tick due this cycle is dropped.
                        if (tick_s) begin
                            presc_r <= {PW{1'b0}};
                        end else begin
                            presc_r <= presc_r;
                        end
                    end else if (tick_s) begin
                        presc_r <= {PW{1'b0}};
                        if (last_sec_s) begin
                            state_r     <= ALARM;
                            running_r   <= 1'b0;
                            alarm_r     <= 1'b1;
                            alarm_cnt_r <= 4'd0;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        presc_r <= presc_r + PRESC_ONE;
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end else begin
                        state_r <= PAUSE;
                    end
                end
                ALARM: begin
                    if (start_stop) begin
                        state_r     <= IDLE;
                        alarm_r     <= 1'b0;
                        presc_r     <= {PW{1'b0}};
                        alarm_cnt_r <= 4'd0;
                    end else if (tick_s) begin
                        presc_r <= {PW{1'b0}};
                        if (alarm_cnt_r >= ALARM_LAST) begin
                            state_r     <= IDLE;
                            alarm_r     <= 1'b0;
                            alarm_cnt_r <= 4'd0;
                        end else begin
                            alarm_cnt_r <= alarm_cnt_r + 4'd1;
                        end
                    end else begin
                        presc_r <= presc_r + PRESC_ONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    presc_r     <= {PW{1'b0}};
                    alarm_cnt_r <= 4'd0;
                    running_r   <= 1'b0;
                    alarm_r     <= 1'b0;
                end
            endcase
        end
    end

    assign min_tens = min_tens_s;
    assign min_ones = min_ones_s;
    assign sec_tens = sec_tens_s;
    assign sec_ones = sec_ones_s;
    assign running  = running_r;
    assign alarm    = alarm_r;

endmodule

// File: tb/tb_egg_timer_counter.sv
// Self-checking bench for egg_timer_counter with TICK_DIV=4, ALARM_SECS=3.
// Expected {MM:SS, running, alarm} snapshots are queued with the cycle in which
// they must appear and compared at the falling edge of that cycle.
module tb_egg_timer_counter;

    localparam int TICK_DIV   = 4;
    localparam int ALARM_SECS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic       inc_min;
    logic       inc_sec;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;
    logic       alarm;

    egg_timer_counter #(
        .TICK_DIV   (TICK_DIV),
        .ALARM_SECS (ALARM_SECS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .inc_min    (inc_min),
        .inc_sec    (inc_sec),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    typedef struct {
        string       tag;
        int          due;
        logic [17:0] val;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    task automatic push_exp(input string tag, input int d, input logic [15:0] mmss,
                            input logic run, input logic alm);
        exp_t e;
        e.tag = tag;
        e.due = cyc + d;
        e.val = {mmss, run, alm};
        sbq.push_back(e);
    endtask

    task automatic drive(input logic ss, input logic clr, input logic im, input logic is);
        start_stop = ss;
        clear      = clr;
        inc_min    = im;
        inc_sec    = is;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        inc_min    = 1'b0;
        inc_sec    = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int m, input int s);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < m; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < s; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Scoreboard compare plus a per-cycle digit range / flag exclusivity check.
    always @(negedge clk) begin
        logic [17:0] obs_v;
        logic [4:0]  legal_v;
        obs_v = {min_tens, min_ones, sec_tens, sec_ones, running, alarm};
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                check(sbq[i].tag, obs_v, sbq[i].val);
                sbq.delete(i);
            end
        end
        if (started) begin
            legal_v = {min_tens <= 4'd9, min_ones <= 4'd9, sec_tens <= 4'd5,
                       sec_ones <= 4'd9, !(running && alarm)};
            check("bcd_range", {13'd0, legal_v}, {13'd0, 5'b11111});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        inc_min    = 1'b0;
        inc_sec    = 1'b0;
        wait_cycles(2);
        push_exp("reset", 0, 16'h0000, 1'b0, 1'b0);
        reset   = 1'b0;
        started = 1'b1;

        // Editing in IDLE
        push_exp("inc_sec1", 1, 16'h0001, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0);
        push_exp("set_0203", 0, 16'h0203, 1'b0, 1'b0);
        repeat (56) drive(1'b0, 1'b0, 1'b0, 1'b1);
        push_exp("sec_59", 0, 16'h0259, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        push_exp("sec_wrap", 0, 16'h0200, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1);
        push_exp("sec_wrap60", 0, 16'h0203, 1'b0, 1'b0);
        repeat (97) drive(1'b0, 1'b0, 1'b1, 1'b0);
        push_exp("min_99", 0, 16'h9903, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        push_exp("min_wrap", 0, 16'h0003, 1'b0, 1'b0);
        push_exp("inc_both", 1, 16'h0104, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);

        // Countdown with borrow across sec_tens and min_ones
        set_time(1, 0);
        push_exp("run_start", 1, 16'h0100, 1'b1, 1'b0);
        push_exp("pre_tick", 4, 16'h0100, 1'b1, 1'b0);
        push_exp("tick_0059", 5, 16'h0059, 1'b1, 1'b0);
        push_exp("tick_0058", 9, 16'h0058, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(9);

        // Borrow into min_tens
        set_time(10, 0);
        push_exp("borrow_mt", 5, 16'h0959, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(5);

        // Expiry and automatic return to IDLE
        set_time(0, 2);
        push_exp("a_start", 1, 16'h0002, 1'b1, 1'b0);
        push_exp("a_0001", 5, 16'h0001, 1'b1, 1'b0);
        push_exp("a_alarm", 9, 16'h0000, 1'b0, 1'b1);
        push_exp("a_still", 20, 16'h0000, 1'b0, 1'b1);
        push_exp("a_idle", 21, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(21);

        // Acknowledge the alarm
        set_time(0, 1);
        push_exp("ack_alarm", 5, 16'h0000, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(4);
        push_exp("ack_idle", 1, 16'h0000, 1'b0, 1'b0);
        push_exp("ack_hold", 3, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(3);

        // Pause keeps digits and fractional second
        set_time(0, 10);
        push_exp("p_start", 1, 16'h0010, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(2);
        push_exp("pause", 1, 16'h0010, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        push_exp("pause_hold", 99, 16'h0010, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        wait_cycles(98);
        push_exp("resume", 1, 16'h0010, 1'b1, 1'b0);
        push_exp("resume_wait", 2, 16'h0010, 1'b1, 1'b0);
        push_exp("resume_tick", 3, 16'h0009, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(2);
        push_exp("run_inc_ign", 1, 16'h0009, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);

        // clear beats start_stop; start at 00:00 is ignored
        push_exp("clear_wins", 1, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        push_exp("zero_start", 1, 16'h0000, 1'b0, 1'b0);
        push_exp("zero_hold", 4, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(4);

        // Synchronous reset mid-count
        set_time(5, 37);
        push_exp("r_start", 1, 16'h0537, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(2);
        push_exp("mid_reset", 1, 16'h0000, 1'b0, 1'b0);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        push_exp("post_reset", 5, 16'h0000, 1'b0, 1'b0);
        wait_cycles(6);

        check("sb_empty", 18'(sbq.size()), 18'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
